// File: rtl/arcade_input_latch.sv
// Input front-end: DIP/game-mode capture from the download stream, joystick latch and coin shaping per vblank rise.
// Download fields update on the sampled strobe; joystick/coin update on the tick edge. No backpressure: every strobe and tick is taken.
module arcade_input_latch #(
  parameter int PLAYERS        = 4,
  parameter int DIP_BYTES      = 8,
  parameter int COIN_FRAMES    = 3,
  parameter int LOCKOUT_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   vblank,
  input  logic [16*PLAYERS-1:0]  joy_in,
  output logic [16*PLAYERS-1:0]  joy_out,
  output logic [PLAYERS-1:0]     coin_out,
  output logic [8*DIP_BYTES-1:0] dip_out,
  output logic                   dip_valid,
  output logic [7:0]             game_mode
);

  localparam logic [7:0] IDX_MODE  = 8'd1;
  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES - 1);
  localparam logic [3:0] LOCK_LOAD = 4'(LOCKOUT_FRAMES - 1);

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_LOCKOUT
  } coin_state_t;

  logic vblank_q;
  logic tick;
  logic dip_wr;
  logic mode_wr;

  // vblank_q resets high so a vblank already asserted at release is not a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vblank_q <= 1'b1;
    else       vblank_q <= vblank;
  end

  assign tick    = vblank & ~vblank_q;
  assign dip_wr  = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr < 25'(DIP_BYTES));
  assign mode_wr = ioctl_wr && (ioctl_index == IDX_MODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dip_out <= '0;
    end else if (dip_wr) begin
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (ioctl_addr[2:0] == 3'(k)) dip_out[8*k +: 8] <= ioctl_dout;
      end
    end
  end

  // The set test comes last so a one-byte bank is marked valid by address 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dip_valid <= 1'b0;
    end else if (dip_wr) begin
      if (ioctl_addr == 25'd0)               dip_valid <= 1'b0;
      if (ioctl_addr == 25'(DIP_BYTES - 1))  dip_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        game_mode <= 8'd0;
    else if (mode_wr) game_mode <= ioctl_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     joy_out <= '0;
    else if (tick) joy_out <= joy_in;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        press;

    // Edge is judged against the previous frame's latched coin bit
    assign press = joy_in[16*p+4] & ~joy_out[16*p+4];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= COIN_IDLE;
        cnt_q   <= 4'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
        case (state_q)
          COIN_IDLE: begin
            if (press) begin
              state_d = COIN_PULSE;
              cnt_d   = COIN_LOAD;
            end
          end
          COIN_PULSE: begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              state_d = COIN_LOCKOUT;
              cnt_d   = LOCK_LOAD;
            end
          end
          COIN_LOCKOUT: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = COIN_IDLE;
          end
          default: begin
            state_d = COIN_IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end

    assign coin_out[p] = (state_q == COIN_PULSE);
  end

endmodule

// File: tb/tb_arcade_input_latch.sv
module tb_arcade_input_latch;
  localparam int PLAYERS = 4;
  localparam int DIPB    = 8;
  localparam int COINF   = 3;
  localparam int LOCKF   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        vblank = 1'b1;
  logic [63:0] joy_in = 64'd0;
  logic [63:0] joy_out;
  logic [3:0]  coin_out;
  logic [63:0] dip_out;
  logic        dip_valid;
  logic [7:0]  game_mode;

  arcade_input_latch #(
    .PLAYERS(PLAYERS), .DIP_BYTES(DIPB), .COIN_FRAMES(COINF), .LOCKOUT_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .vblank(vblank),
    .joy_in(joy_in), .joy_out(joy_out), .coin_out(coin_out), .dip_out(dip_out),
    .dip_valid(dip_valid), .game_mode(game_mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] joy;
    logic [3:0]  coin;
    logic [63:0] dip;
    logic        dv;
    logic [7:0]  gm;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame-indexed view of the block
  logic        m_vbq;
  logic [63:0] m_joy, m_dip;
  logic        m_dv;
  logic [7:0]  m_gm;
  int          m_n;
  int          m_start[PLAYERS];

  // Pending download strobe for the next step
  logic        d_wr = 1'b0;
  logic [7:0]  d_idx = 8'd0;
  logic [24:0] d_addr = 25'd0;
  logic [7:0]  d_dout = 8'd0;
  logic        cur_vb = 1'b1;
  logic [63:0] cur_joy = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vbq = 1'b1; m_joy = '0; m_dip = '0; m_dv = 1'b0; m_gm = 8'd0; m_n = 0;
    for (int p = 0; p < PLAYERS; p++) m_start[p] = -1;
  endtask

  task automatic step(input bit rst_i, input logic vb, input logic [63:0] joy);
    exp_t e;
    logic tk;
    logic [PLAYERS-1:0] press;
    int a;
    @(negedge clk);
    reset = rst_i; vblank = vb; joy_in = joy;
    ioctl_wr = d_wr; ioctl_index = d_idx; ioctl_addr = d_addr; ioctl_dout = d_dout;
    cur_vb = vb; cur_joy = joy;
    if (rst_i) begin
      model_reset();
    end else begin
      tk = vb & ~m_vbq;
      m_vbq = vb;
      if (d_wr && d_idx == 8'd254 && d_addr < 25'(DIPB)) begin
        a = int'(d_addr);
        m_dip[8*a +: 8] = d_dout;
        if (a == 0) m_dv = 1'b0;
        if (a == DIPB - 1) m_dv = 1'b1;
      end
      if (d_wr && d_idx == 8'd1) m_gm = d_dout;
      if (tk) begin
        m_n++;
        for (int p = 0; p < PLAYERS; p++) begin
          press[p] = joy[16*p+4] & ~m_joy[16*p+4];
          if (press[p] && (m_start[p] < 0 || m_n - m_start[p] >= COINF + LOCKF + 1))
            m_start[p] = m_n;
        end
        m_joy = joy;
      end
    end
    e.joy = m_joy; e.dip = m_dip; e.dv = m_dv; e.gm = m_gm;
    for (int p = 0; p < PLAYERS; p++)
      e.coin[p] = (m_start[p] >= 0) && (m_n - m_start[p] < COINF);
    sb.push_back(e);
    if (rst_i) begin
      #1;
      check("async_reset_coin", {60'd0, coin_out}, 64'd0);
      check("async_reset_joy", joy_out, 64'd0);
    end
  endtask

  task automatic dl(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dout);
    d_wr = 1'b1; d_idx = idx; d_addr = addr; d_dout = dout;
    step(1'b0, cur_vb, cur_joy);
    d_wr = 1'b0;
  endtask

  task automatic frame(input logic [63:0] joy, input int nlow, input int nhigh, input bit rnd);
    for (int i = 0; i < nlow + nhigh; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        d_wr = 1'b1;
        case ($urandom_range(0, 2))
          0: d_idx = 8'd1;
          1: d_idx = 8'd254;
          default: d_idx = 8'd3;
        endcase
        d_addr = 25'($urandom_range(0, 10));
        d_dout = 8'($urandom);
      end
      step(1'b0, (i >= nlow), joy);
      d_wr = 1'b0;
    end
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("joy_out", joy_out, e.joy);
        check("coin_out", {60'd0, coin_out}, {60'd0, e.coin});
        check("dip_out", dip_out, e.dip);
        check("dip_valid", {63'd0, dip_valid}, {63'd0, e.dv});
        check("game_mode", {56'd0, game_mode}, {56'd0, e.gm});
      end
    end
  end

  initial begin
    logic [63:0] j;
    model_reset();
    // Reset with vblank high, then release: no tick until vblank falls and rises
    repeat (3) step(1'b1, 1'b1, 64'h1234_5678_9abc_def0);
    frame(64'h1234_5678_9abc_def0, 0, 5, 1'b0);
    frame(64'h1234_5678_9abc_def0, 2, 3, 1'b0);

    // DIP load, out-of-range write, then address 0 clears valid
    for (int k = 0; k < 8; k++) begin
      j = 64'h11 * (k + 1);
      dl(8'd254, 25'(k), j[7:0]);
      step(1'b0, cur_vb, cur_joy);
    end
    dl(8'd254, 25'd9, 8'hEE);
    dl(8'd254, 25'd0, 8'hA5);
    dl(8'd254, 25'd7, 8'h5A);

    // Game mode: last write wins, other indices ignored
    dl(8'd1, 25'd0, 8'h02);
    dl(8'd1, 25'd0, 8'h03);
    dl(8'd2, 25'd0, 8'h77);

    // Player 1 coin held for 20 frames
    frame(64'd0, 2, 2, 1'b0);
    for (int f = 0; f < 20; f++) frame(64'h0010_0000, 2, 2, 1'b0);
    frame(64'd0, 2, 2, 1'b0);

    // Player 0 coin toggled every frame pair across the lockout window
    for (int f = 0; f < 32; f++) frame((f % 4 < 2) ? 64'h10 : 64'h0, 1, 2, 1'b0);
    for (int f = 0; f < 14; f++) frame(64'd0, 1, 2, 1'b0);

    // Players 0 and 3 together, then reset during the pulse
    frame(64'h0010_0000_0000_0010, 2, 2, 1'b0);
    frame(64'h0010_0000_0000_0010, 2, 2, 1'b0);
    step(1'b1, 1'b1, 64'h0010_0000_0000_0010);
    step(1'b1, 1'b0, 64'h0010_0000_0000_0010);
    frame(64'h0010_0000_0000_0010, 2, 2, 1'b0);

    // Long vblank high and low stretches: no ticks
    frame(64'hFFFF_FFFF_FFFF_FFFF, 20, 20, 1'b0);

    // Randomized frames with interleaved downloads and occasional reset
    for (int f = 0; f < 200; f++) begin
      j = {$urandom, $urandom};
      if ($urandom_range(0, 39) == 0) step(1'b1, 1'($urandom_range(0, 1)), j);
      frame(j, $urandom_range(1, 4), $urandom_range(1, 4), 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
